// File: rtl/tlb_lookup_arb.sv
// Arbitrates INST / DATA / PROBE onto the shared TLB search port; two-stage pipelined.
// Define TLB_ARB_RR_EN for DATA/INST round-robin instead of fixed priority with starvation guard.
module tlb_lookup_arb #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [18:0] inst_vpn2,
    input  logic        inst_odd,
    output logic        inst_ready,
    input  logic        data_req,
    input  logic [18:0] data_vpn2,
    input  logic        data_odd,
    output logic        data_ready,
    input  logic        probe_req,
    output logic        probe_ready,
    input  logic [31:0] c0_entryhi,
    input  logic        mtc0_pending,
    input  logic        flush,
    output logic [18:0] s_vpn2,
    output logic        s_odd_page,
    output logic [7:0]  s_asid,
    input  logic        s_found,
    input  logic [3:0]  s_index,
    input  logic [19:0] s_pfn,
    input  logic [2:0]  s_c,
    input  logic        s_d,
    input  logic        s_v,
    output logic        resp_valid,
    output logic [1:0]  resp_id,
    output logic        resp_found,
    output logic [3:0]  resp_index,
    output logic [19:0] resp_pfn,
    output logic [2:0]  resp_c,
    output logic        resp_d,
    output logic        resp_v
);

    localparam logic [1:0] ID_INST  = 2'b01;
    localparam logic [1:0] ID_DATA  = 2'b10;
    localparam logic [1:0] ID_PROBE = 2'b11;

    logic        probe_ok, data_ok, inst_ok, inst_pri;
    logic        grant_probe, grant_data, grant_inst;
    logic        capture;

    logic        s1_valid_q, s1_valid_d;
    logic [1:0]  s1_id_q, s1_id_d;
    logic [18:0] s1_vpn2_q, s1_vpn2_d;
    logic        s1_odd_q, s1_odd_d;

    logic        resp_valid_q, resp_valid_d;
    logic [1:0]  resp_id_q, resp_id_d;
    logic        resp_found_q, resp_found_d;
    logic [3:0]  resp_index_q, resp_index_d;
    logic [19:0] resp_pfn_q, resp_pfn_d;
    logic [2:0]  resp_c_q, resp_c_d;
    logic        resp_d_q, resp_d_d;
    logic        resp_v_q, resp_v_d;

`ifdef TLB_ARB_RR_EN
    logic        last_data_q, last_data_d;
`else
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
`endif

    logic unused_entryhi;
    assign unused_entryhi = ^c0_entryhi[12:8];

    // Grant: PROBE first (unless a CP0 write is in flight), then DATA/INST.
    always_comb begin
        probe_ok = probe_req && !mtc0_pending && !reset;
        data_ok  = data_req && !flush && !reset;
        inst_ok  = inst_req && !flush && !reset;
`ifdef TLB_ARB_RR_EN
        inst_pri = last_data_q;
`else
        inst_pri = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
`endif
        grant_probe = probe_ok;
        grant_data  = !probe_ok && data_ok && !(inst_pri && inst_ok);
        grant_inst  = !probe_ok && inst_ok && !grant_data;
    end

    assign probe_ready = grant_probe;
    assign data_ready  = grant_data;
    assign inst_ready  = grant_inst;

    // Stage 1 holds the accepted request while the TLB is searched.
    always_comb begin
        s1_valid_d = grant_probe || grant_data || grant_inst;
        s1_id_d    = s1_id_q;
        s1_vpn2_d  = s1_vpn2_q;
        s1_odd_d   = s1_odd_q;
        if (grant_probe) begin
            s1_id_d   = ID_PROBE;
            s1_vpn2_d = c0_entryhi[31:13];
            s1_odd_d  = 1'b0;
        end else if (grant_data) begin
            s1_id_d   = ID_DATA;
            s1_vpn2_d = data_vpn2;
            s1_odd_d  = data_odd;
        end else if (grant_inst) begin
            s1_id_d   = ID_INST;
            s1_vpn2_d = inst_vpn2;
            s1_odd_d  = inst_odd;
        end
    end

    assign s_vpn2     = s1_valid_q ? s1_vpn2_q : 19'd0;
    assign s_odd_page = s1_valid_q ? s1_odd_q : 1'b0;
    assign s_asid     = s1_valid_q ? c0_entryhi[7:0] : 8'd0;

    // Flush squashes INST/DATA lookups in stage 1; probes always complete.
    always_comb begin
        capture      = s1_valid_q && ((s1_id_q == ID_PROBE) || !flush);
        resp_valid_d = capture;
        resp_id_d    = resp_id_q;
        resp_found_d = resp_found_q;
        resp_index_d = resp_index_q;
        resp_pfn_d   = resp_pfn_q;
        resp_c_d     = resp_c_q;
        resp_d_d     = resp_d_q;
        resp_v_d     = resp_v_q;
        if (capture) begin
            resp_id_d    = s1_id_q;
            resp_found_d = s_found;
            resp_index_d = s_index;
            resp_pfn_d   = s_pfn;
            resp_c_d     = s_c;
            resp_d_d     = s_d;
            resp_v_d     = s_v;
        end
    end

`ifdef TLB_ARB_RR_EN
    always_comb begin
        last_data_d = last_data_q;
        if (grant_data) begin
            last_data_d = 1'b1;
        end else if (grant_inst) begin
            last_data_d = 1'b0;
        end
    end
`else
    // Counts consecutive cycles INST is denied; saturates at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!inst_req || grant_inst) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_id_q      <= '0;
            s1_vpn2_q    <= '0;
            s1_odd_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_found_q <= 1'b0;
            resp_index_q <= '0;
            resp_pfn_q   <= '0;
            resp_c_q     <= '0;
            resp_d_q     <= 1'b0;
            resp_v_q     <= 1'b0;
`ifdef TLB_ARB_RR_EN
            last_data_q  <= 1'b0;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s1_vpn2_q    <= s1_vpn2_d;
            s1_odd_q     <= s1_odd_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_found_q <= resp_found_d;
            resp_index_q <= resp_index_d;
            resp_pfn_q   <= resp_pfn_d;
            resp_c_q     <= resp_c_d;
            resp_d_q     <= resp_d_d;
            resp_v_q     <= resp_v_d;
`ifdef TLB_ARB_RR_EN
            last_data_q  <= last_data_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_found = resp_found_q;
    assign resp_index = resp_index_q;
    assign resp_pfn   = resp_pfn_q;
    assign resp_c     = resp_c_q;
    assign resp_d     = resp_d_q;
    assign resp_v     = resp_v_q;

endmodule

// File: tb/tb_tlb_lookup_arb.sv
// Scoreboard bench for tlb_lookup_arb: reference model predicts grants and responses.
module tb_tlb_lookup_arb;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_odd, inst_ready;
    logic [18:0] inst_vpn2;
    logic        data_req, data_odd, data_ready;
    logic [18:0] data_vpn2;
    logic        probe_req, probe_ready;
    logic [31:0] c0_entryhi;
    logic        mtc0_pending, flush;
    logic [18:0] s_vpn2;
    logic        s_odd_page;
    logic [7:0]  s_asid;
    logic        s_found, s_d, s_v;
    logic [3:0]  s_index;
    logic [19:0] s_pfn;
    logic [2:0]  s_c;
    logic        resp_valid, resp_found, resp_d, resp_v;
    logic [1:0]  resp_id;
    logic [3:0]  resp_index;
    logic [19:0] resp_pfn;
    logic [2:0]  resp_c;

    tlb_lookup_arb dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_vpn2(inst_vpn2), .inst_odd(inst_odd), .inst_ready(inst_ready),
        .data_req(data_req), .data_vpn2(data_vpn2), .data_odd(data_odd), .data_ready(data_ready),
        .probe_req(probe_req), .probe_ready(probe_ready),
        .c0_entryhi(c0_entryhi), .mtc0_pending(mtc0_pending), .flush(flush),
        .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
        .s_found(s_found), .s_index(s_index), .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_found(resp_found),
        .resp_index(resp_index), .resp_pfn(resp_pfn), .resp_c(resp_c),
        .resp_d(resp_d), .resp_v(resp_v)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Fake TLB contents: {found, index, pfn, c, d, v} as a function of the search key.
    function automatic logic [29:0] tlb_f(input logic [18:0] v, input logic o, input logic [7:0] a);
        logic [19:0] pfn;
        pfn = (v == 19'h12345 && o) ? 20'hABCDE : ({1'b0, v} ^ {a, 12'h5a5} ^ {19'd0, o});
        return {^{v, o, a}, v[3:0] ^ a[3:0], pfn, v[6:4], a[0], v[7] ^ o};
    endfunction

    always_comb {s_found, s_index, s_pfn, s_c, s_d, s_v} = tlb_f(s_vpn2, s_odd_page, s_asid);

    typedef struct {
        int          due;
        logic [1:0]  id;
        logic [29:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        else n_pass++;
    endtask

    // Reference model state: what sits in the search stage, and INST fairness history.
    logic        m_s1_valid = 1'b0;
    logic [1:0]  m_s1_id;
    logic [18:0] m_s1_vpn2;
    logic        m_s1_odd;
    int          m_denied = 0;
    logic        m_last_data = 1'b0;
    logic        prev_reset = 1'b0;

    task automatic model_step();
        int   win;
        logic inst_el, data_el, inst_favoured;
        exp_t e;
        chk("s_vpn2", 32'(s_vpn2), m_s1_valid ? 32'(m_s1_vpn2) : 32'd0);
        chk("s_odd_page", 32'(s_odd_page), m_s1_valid ? 32'(m_s1_odd) : 32'd0);
        chk("s_asid", 32'(s_asid), m_s1_valid ? 32'(c0_entryhi[7:0]) : 32'd0);
        if (prev_reset) begin
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_resp_id", 32'(resp_id), 32'd0);
            chk("rst_resp_pfn", 32'(resp_pfn), 32'd0);
        end
        if (!reset && m_s1_valid && (m_s1_id == 2'b11 || !flush)) begin
            e.due = cyc + 1;
            e.id  = m_s1_id;
            e.res = tlb_f(m_s1_vpn2, m_s1_odd, c0_entryhi[7:0]);
            exp_q.push_back(e);
        end
`ifdef TLB_ARB_RR_EN
        inst_favoured = m_last_data;
`else
        inst_favoured = (m_denied >= STARVE_LIMIT);
`endif
        win = 0;
        if (!reset) begin
            inst_el = inst_req && !flush;
            data_el = data_req && !flush;
            if (probe_req && !mtc0_pending) win = 3;
            else if (inst_el && data_el) win = inst_favoured ? 1 : 2;
            else if (data_el) win = 2;
            else if (inst_el) win = 1;
        end
        chk("probe_ready", 32'(probe_ready), 32'(win == 3));
        chk("data_ready", 32'(data_ready), 32'(win == 2));
        chk("inst_ready", 32'(inst_ready), 32'(win == 1));
        if (reset) begin
            m_s1_valid  = 1'b0;
            m_denied    = 0;
            m_last_data = 1'b0;
        end else begin
            m_s1_valid = (win != 0);
            if (win == 3) begin m_s1_id = 2'b11; m_s1_vpn2 = c0_entryhi[31:13]; m_s1_odd = 1'b0; end
            if (win == 2) begin m_s1_id = 2'b10; m_s1_vpn2 = data_vpn2; m_s1_odd = data_odd; end
            if (win == 1) begin m_s1_id = 2'b01; m_s1_vpn2 = inst_vpn2; m_s1_odd = inst_odd; end
            if (inst_req && win != 1) m_denied++;
            else m_denied = 0;
            if (win == 2) m_last_data = 1'b1;
            if (win == 1) m_last_data = 1'b0;
        end
        prev_reset = reset;
    endtask

    // Monitor: every response must match the oldest expected one, on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("resp_spurious", 32'(resp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_cycle", 32'(cyc), 32'(e.due));
                chk("resp_id", 32'(resp_id), 32'(e.id));
                chk("resp_data", 32'({resp_found, resp_index, resp_pfn, resp_c, resp_d, resp_v}), 32'(e.res));
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            chk("resp_missing", 32'(resp_valid), 32'd1);
            void'(exp_q.pop_front());
        end
    end

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic dr, input logic pr,
                         input logic mt, input logic fl, input logic rs);
        inst_req     = ir;
        data_req     = dr;
        probe_req    = pr;
        mtc0_pending = mt;
        flush        = fl;
        reset        = rs;
        inst_vpn2    = 19'($urandom);
        inst_odd     = 1'($urandom);
        data_vpn2    = 19'($urandom);
        data_odd     = 1'($urandom);
    endtask

    initial begin
        c0_entryhi = 32'h2468_A05C;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        // 1: lone INST lookup with known PFN
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        inst_vpn2 = 19'h12345;
        inst_odd  = 1'b1;
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        // 2: all three at once; each drops after being granted
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); repeat (3) tick();
        // 3: DATA and INST held; INST forced through after the starvation limit
        repeat (7) begin drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick(); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); repeat (3) tick();
        // 4: INST accepted then flushed
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); repeat (3) tick();
        // 4b: probe in flight survives a flush
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); repeat (3) tick();
        // 5: probe blocked by pending CP0 write
        repeat (3) begin drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick(); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); repeat (3) tick();
        // 6: reset while a lookup sits in stage 1
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); repeat (3) tick();
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) != 0),
                  1'($urandom_range(3, 0) == 0), 1'($urandom_range(3, 0) == 0),
                  1'($urandom_range(7, 0) == 0), 1'($urandom_range(63, 0) == 0));
            c0_entryhi = $urandom;
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
